// File: rtl/fetch_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_cycle
//  Description : Instruction-fetch stage with IF/ID pipeline register.
//                A three-state controller (BOOT -> RUN -> HALT) sequences the
//                fetch PC. Word-addressed 9-bit PC, 33-bit instructions.
//                Redirects (return has priority over branch) beat StallF.
//                The all-ones instruction word halts the fetch stage until
//                reset.
//  Ports       : clk             - clock, rising edge
//                rst             - asynchronous active-low reset
//                StallF/StallD   - hold PC / hold IF/ID
//                FlushD          - load NOP into IF/ID
//                PCSrcE/PCTargetE             - branch/jump redirect
//                PCReturnSignalE/PCReturnE    - return redirect
//                InstrF          - instruction memory read data at PCF
//                PCF             - current fetch address
//                InstrD/PCD/PCPlus4D - IF/ID register contents
//                HaltedF         - high while halted
//                FetchCountF/StallCountF - saturating performance counters
//                                  (only with FETCH_PERF_COUNT_EN defined)
//  Options     : `define FETCH_PERF_COUNT_EN to add the performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [8:0]  PCTargetE,
    input  logic        PCReturnSignalE,
    input  logic [8:0]  PCReturnE,
    input  logic [32:0] InstrF,
    output logic [8:0]  PCF,
    output logic [32:0] InstrD,
    output logic [8:0]  PCD,
    output logic [8:0]  PCPlus4D,
    output logic        HaltedF
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0] FetchCountF,
    output logic [15:0] StallCountF
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [32:0] C_HALT_WORD = 33'h1_FFFF_FFFF;
    localparam logic [32:0] C_NOP_INSTR = 33'h0;

    state_t      state_q, state_d;
    logic [8:0]  pc_q, pc_d;
    logic [32:0] instr_q, instr_d;
    logic [8:0]  pcd_q, pcd_d;
    logic [8:0]  pc4d_q, pc4d_d;

    logic [8:0]  w_pc_plus1;
    logic        w_redirect;
    logic        w_halt_det;

    // 9-bit add wraps 511 -> 0 naturally.
    assign w_pc_plus1 = pc_q + 9'd1;
    assign w_redirect = PCReturnSignalE | PCSrcE;
    // A halt word on a redirected (wrong) path or under a fetch stall is ignored.
    assign w_halt_det = (state_q == S_RUN) && !w_redirect && !StallF &&
                        (InstrF == C_HALT_WORD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= 9'd0;
            instr_q <= C_NOP_INSTR;
            pcd_q   <= 9'd0;
            pc4d_q  <= 9'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4d_q  <= pc4d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc4d_d  = pc4d_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                pc_d    = 9'd0;
                instr_d = C_NOP_INSTR;
                pcd_d   = 9'd0;
                pc4d_d  = 9'd0;
            end
            S_RUN: begin
                if (PCReturnSignalE) begin
                    pc_d = PCReturnE;
                end else if (PCSrcE) begin
                    pc_d = PCTargetE;
                end else if (!StallF) begin
                    pc_d = w_pc_plus1;
                end

                if (w_halt_det) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                    instr_d = C_NOP_INSTR;
                    pcd_d   = 9'd0;
                    pc4d_d  = 9'd0;
                end else if (FlushD) begin
                    instr_d = C_NOP_INSTR;
                    pcd_d   = 9'd0;
                    pc4d_d  = 9'd0;
                end else if (!StallD) begin
                    instr_d = InstrF;
                    pcd_d   = pc_q;
                    pc4d_d  = w_pc_plus1;
                end
            end
            S_HALT: begin
                // Only reset leaves HALT; the IF/ID register keeps draining NOPs.
                instr_d = C_NOP_INSTR;
                pcd_d   = 9'd0;
                pc4d_d  = 9'd0;
            end
            default: begin
                state_d = S_BOOT;
                pc_d    = 9'd0;
                instr_d = C_NOP_INSTR;
                pcd_d   = 9'd0;
                pc4d_d  = 9'd0;
            end
        endcase
    end

    assign PCF      = pc_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc4d_q;
    assign HaltedF  = (state_q == S_HALT);

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fcnt_q;
    logic [15:0] scnt_q;
    logic        w_fetch_inc;
    logic        w_stall_inc;

    // A halting cycle loads a NOP, so it is not a fetch.
    assign w_fetch_inc = (state_q == S_RUN) && !w_halt_det && !FlushD && !StallD;
    assign w_stall_inc = (state_q == S_RUN) && StallF && !w_redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q <= 16'd0;
            scnt_q <= 16'd0;
        end else begin
            if (w_fetch_inc && (fcnt_q != 16'hFFFF)) begin
                fcnt_q <= fcnt_q + 16'd1;
            end
            if (w_stall_inc && (scnt_q != 16'hFFFF)) begin
                scnt_q <= scnt_q + 16'd1;
            end
        end
    end

    assign FetchCountF = fcnt_q;
    assign StallCountF = scnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_cycle
//  Description : Self-checking bench for fetch_cycle. Directed vector table,
//                hand-written halt/reset sequence, optional counter checks
//                (FETCH_PERF_COUNT_EN) and a randomized run against a
//                cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_cycle;

    localparam logic [32:0] C_HALT = 33'h1_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE, PCReturnSignalE;
    logic [8:0]  PCTargetE, PCReturnE;
    logic [32:0] InstrF;
    logic [8:0]  PCF, PCD, PCPlus4D;
    logic [32:0] InstrD;
    logic        HaltedF;
`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] FetchCountF, StallCountF;
`endif

    logic [32:0] rom [512];
    int n_cmp;
    int n_fail;

    fetch_cycle dut (
        .clk             (clk),
        .rst             (rst),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .PCSrcE          (PCSrcE),
        .PCTargetE       (PCTargetE),
        .PCReturnSignalE (PCReturnSignalE),
        .PCReturnE       (PCReturnE),
        .InstrF          (InstrF),
        .PCF             (PCF),
        .InstrD          (InstrD),
        .PCD             (PCD),
        .PCPlus4D        (PCPlus4D),
        .HaltedF         (HaltedF)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .FetchCountF     (FetchCountF),
        .StallCountF     (StallCountF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory.
    always_comb InstrF = rom[PCF];

    // ------------------------------------------------------------------
    // Reference model: architectural view of the fetch stage
    // ------------------------------------------------------------------
    bit          m_boot, m_halt;
    int          m_pc, m_pcd, m_pc4d, m_fcnt, m_scnt;
    logic [32:0] m_instr;

    task automatic model_reset();
        m_boot = 1; m_halt = 0;
        m_pc = 0; m_pcd = 0; m_pc4d = 0; m_instr = '0;
        m_fcnt = 0; m_scnt = 0;
    endtask

    task automatic model_nop();
        m_instr = '0; m_pcd = 0; m_pc4d = 0;
    endtask

    // Advance one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [32:0] fetched;
        int  nxt;
        bit  redir, hlt;
        fetched = rom[m_pc];
        if (m_boot) begin
            m_boot = 0; m_pc = 0; model_nop();
        end else if (m_halt) begin
            model_nop();
        end else begin
            redir = PCReturnSignalE || PCSrcE;
            hlt   = !redir && !StallF && (fetched == C_HALT);
            if (PCReturnSignalE)  nxt = int'(PCReturnE);
            else if (PCSrcE)      nxt = int'(PCTargetE);
            else if (StallF)      nxt = m_pc;
            else                  nxt = (m_pc + 1) % 512;
            if (StallF && !redir && m_scnt < 65535) m_scnt++;
            if (hlt) begin
                model_nop(); m_halt = 1;
            end else begin
                if (FlushD) model_nop();
                else if (!StallD) begin
                    m_instr = fetched; m_pcd = m_pc; m_pc4d = (m_pc + 1) % 512;
                    if (m_fcnt < 65535) m_fcnt++;
                end
                m_pc = nxt;
            end
        end
    endtask

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("PCF",      33'(PCF),      33'(m_pc));
        chk("InstrD",   InstrD,        m_instr);
        chk("PCD",      33'(PCD),      33'(m_pcd));
        chk("PCPlus4D", 33'(PCPlus4D), 33'(m_pc4d));
        chk("HaltedF",  33'(HaltedF),  33'(m_halt));
`ifdef FETCH_PERF_COUNT_EN
        chk("FetchCountF", 33'(FetchCountF), 33'(m_fcnt));
        chk("StallCountF", 33'(StallCountF), 33'(m_scnt));
`endif
    endtask

    task automatic drive(input bit sf, input bit sd, input bit fl, input bit src,
                         input int tgt, input bit ret, input int rtg);
        StallF = sf; StallD = sd; FlushD = fl; PCSrcE = src;
        PCTargetE = 9'(tgt); PCReturnSignalE = ret; PCReturnE = 9'(rtg);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous assertion checked between edges, release away from the edge.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_PCF",     33'(PCF),      33'd0);
        chk("rst_InstrD",  InstrD,        33'd0);
        chk("rst_PCD",     33'(PCD),      33'd0);
        chk("rst_PCPlus4D",33'(PCPlus4D), 33'd0);
        chk("rst_HaltedF", 33'(HaltedF),  33'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("rst_FetchCountF", 33'(FetchCountF), 33'd0);
        chk("rst_StallCountF", 33'(StallCountF), 33'd0);
`endif
        tick();
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit sf, sd, fl, src; int tgt; bit ret; int rtg;
        int e_pc; logic [32:0] e_instr; int e_pcd; int e_pc4d; bit e_halt;
    } vec_t;

    function automatic vec_t mk(bit sf, bit sd, bit fl, bit src, int tgt, bit ret, int rtg,
                                int e_pc, logic [32:0] e_instr, int e_pcd, int e_pc4d, bit e_halt);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.src = src; v.tgt = tgt; v.ret = ret; v.rtg = rtg;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_pc4d = e_pc4d; v.e_halt = e_halt;
        return v;
    endfunction

    initial begin
        vec_t tbl[12];
        n_cmp = 0; n_fail = 0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) rom[i] = 33'(i);
        model_reset();

        // Expected values per edge, starting from BOOT with ROM = address.
        tbl[0]  = mk(0,0,0,0,  0,0,0,   0,  33'd0,   0,   0, 0); // BOOT -> RUN, PC held
        tbl[1]  = mk(0,0,0,0,  0,0,0,   1,  33'd0,   0,   1, 0); // word 0
        tbl[2]  = mk(0,0,0,0,  0,0,0,   2,  33'd1,   1,   2, 0); // word 1
        tbl[3]  = mk(0,0,0,1, 20,0,0,  20,  33'd2,   2,   3, 0); // branch to 20
        tbl[4]  = mk(1,1,0,0,  0,0,0,  20,  33'd2,   2,   3, 0); // stall
        tbl[5]  = mk(1,1,0,0,  0,0,0,  20,  33'd2,   2,   3, 0);
        tbl[6]  = mk(1,1,0,0,  0,0,0,  20,  33'd2,   2,   3, 0);
        tbl[7]  = mk(1,1,0,1,100,0,0, 100,  33'd2,   2,   3, 0); // redirect beats stall
        tbl[8]  = mk(0,0,1,1, 50,1,7,   7,  33'd0,   0,   0, 0); // return wins, flush
        tbl[9]  = mk(0,0,0,1,511,0,0, 511,  33'd7,   7,   8, 0);
        tbl[10] = mk(0,0,0,0,  0,0,0,   0, 33'd511, 511,  0, 0); // wrap
        tbl[11] = mk(0,0,0,0,  0,0,0,   1,  33'd0,   0,   1, 0);

        #2;
        chk("reset_PCF",     33'(PCF),     33'd0);
        chk("reset_InstrD",  InstrD,       33'd0);
        chk("reset_HaltedF", 33'(HaltedF), 33'd0);
        tick();
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].sf, tbl[i].sd, tbl[i].fl, tbl[i].src, tbl[i].tgt, tbl[i].ret, tbl[i].rtg);
            tick();
            chk($sformatf("vec%0d_PCF", i),      33'(PCF),      33'(tbl[i].e_pc));
            chk($sformatf("vec%0d_InstrD", i),   InstrD,        tbl[i].e_instr);
            chk($sformatf("vec%0d_PCD", i),      33'(PCD),      33'(tbl[i].e_pcd));
            chk($sformatf("vec%0d_PCPlus4D", i), 33'(PCPlus4D), 33'(tbl[i].e_pc4d));
            chk($sformatf("vec%0d_HaltedF", i),  33'(HaltedF),  33'(tbl[i].e_halt));
        end

        // Halt sequence at PC 9.
        rom[9] = C_HALT;
        drive(0,0,0,1,9,0,0); tick();
        chk("halt_goto9", 33'(PCF), 33'd9);
        drive(0,0,0,1,9,0,0); tick();          // halt word on a redirected path
        chk("wrongpath_HaltedF", 33'(HaltedF), 33'd0);
        chk("wrongpath_PCF",     33'(PCF),     33'd9);
        chk("wrongpath_InstrD",  InstrD,       C_HALT);
        drive(0,0,0,0,0,0,0); tick();
        chk("halt_HaltedF", 33'(HaltedF), 33'd1);
        chk("halt_PCF",     33'(PCF),     33'd9);
        chk("halt_InstrD",  InstrD,       33'd0);
        drive(1,0,0,1,50,1,30); tick();        // redirects and stalls ignored
        chk("halt_hold_PCF",     33'(PCF),     33'd9);
        chk("halt_hold_HaltedF", 33'(HaltedF), 33'd1);
        chk("halt_hold_InstrD",  InstrD,       33'd0);
        drive(0,0,0,0,0,0,0);
        do_reset();
        tick();
        chk("post_halt_boot_PCF",  33'(PCF),     33'd0);
        chk("post_halt_HaltedF",   33'(HaltedF), 33'd0);
        rom[9] = 33'd9;

`ifdef FETCH_PERF_COUNT_EN
        do_reset();
        tick();                                 // BOOT
        for (int i = 0; i < 10; i++) tick();    // 10 fetches
        drive(1,1,0,0,0,0,0);
        for (int i = 0; i < 3; i++) tick();     // 3 stalls
        chk("cnt_fetch10", 33'(FetchCountF), 33'd10);
        chk("cnt_stall3",  33'(StallCountF), 33'd3);
        drive(1,0,0,0,0,0,0);
        for (int i = 0; i < 65540; i++) tick();
        chk("cnt_fetch_sat", 33'(FetchCountF), 33'hFFFF);
        chk("cnt_stall_sat", 33'(StallCountF), 33'hFFFF);
        drive(0,0,0,0,0,0,0);
`endif

        // Randomized run against the reference model.
        for (int i = 0; i < 512; i++) rom[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
        for (int k = 0; k < 4; k++) rom[$urandom_range(0, 511)] = C_HALT;
        drive(0,0,0,0,0,0,0);
        do_reset();
        chk_model();
        begin
            int halt_cycles;
            halt_cycles = 0;
            for (int c = 0; c < 3000; c++) begin
                if (($urandom_range(0, 199) == 0) || halt_cycles > 6) begin
                    halt_cycles = 0;
                    do_reset();
                    chk_model();
                end else begin
                    drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                          int'($urandom_range(0, 511)), $urandom_range(0, 9) == 0,
                          int'($urandom_range(0, 511)));
                    model_step();
                    tick();
                    chk_model();
                    if (m_halt) halt_cycles++;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_cycle.md
FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset; clears all state immediately on assertion.
REQ-003 SHALL have port StallF, input, 1, hold PC.
REQ-004 SHALL have port StallD, input, 1, hold IF/ID register.
REQ-005 SHALL have port FlushD, input, 1, load NOP into IF/ID.
REQ-006 SHALL have port PCSrcE, input, 1, taken branch/jump redirect.
REQ-007 SHALL have port PCTargetE, input, 9, redirect target.
REQ-008 SHALL have port PCReturnSignalE, input, 1, return redirect.
REQ-009 SHALL have port PCReturnE, input, 9, return target.
REQ-010 SHALL have port InstrF, input, 33, combinational instruction-memory read data at PCF.
REQ-011 SHALL have port PCF, output, 9, current fetch address.
REQ-012 SHALL have ports InstrD (33), PCD (9), PCPlus4D (9), outputs, IF/ID register contents.
REQ-013 SHALL have port HaltedF, output, 1, high while in HALT.

Function
REQ-014 SHALL implement FSM BOOT -> RUN -> HALT; BOOT lasts exactly one cycle after rst deasserts, PC held at 0, IF/ID loads NOP.
REQ-015 SHALL compute PCPlus4F = (PCF + 1) mod 512 (word addressing); PC 511 wraps to 0.
REQ-016 SHALL select next PC in RUN by priority: PCReturnSignalE -> PCReturnE; else PCSrcE -> PCTargetE; else StallF -> hold; else PCPlus4F.
REQ-017 SHALL let a redirect override StallF (a redirect is never lost).
REQ-018 SHALL, when both return and branch assert, take PCReturnE.
REQ-019 SHALL define NOP as InstrD = 33'h0, PCD = 0, PCPlus4D = 0.
REQ-020 SHALL update IF/ID by priority: FlushD -> NOP; else StallD -> hold; else {InstrF, PCF, PCPlus4F}.
REQ-021 SHALL treat InstrF = 33'h1_FFFF_FFFF fetched in RUN, with no redirect and StallF low, as HALT: PC frozen, IF/ID loads NOP, FSM -> HALT next edge.
REQ-022 SHALL ignore the halt encoding when a redirect is asserted in the same cycle (wrong-path), remaining in RUN.
REQ-023 SHALL in HALT freeze PC, ignore redirects and stalls, load NOP into IF/ID (FlushD still honoured), and exit only via rst.
REQ-024 SHALL have one-cycle fetch latency: instruction at PCF appears on InstrD after the next rising edge.

Reset
REQ-025 SHALL on rst low force PCF = 0, InstrD = 0, PCD = 0, PCPlus4D = 0, HaltedF = 0, FSM = BOOT, counters = 0, regardless of clock.
REQ-026 SHALL, on reset mid-operation (including in HALT), discard all in-flight state and restart from BOOT.

Configuration
REQ-027 SHALL, when FETCH_PERF_COUNT_EN is defined, add outputs FetchCountF[15:0] (increments each RUN cycle the IF/ID register loads a non-flushed instruction) and StallCountF[15:0] (increments each RUN cycle StallF is high with no redirect); both saturate at 16'hFFFF.
REQ-028 SHALL, when FETCH_PERF_COUNT_EN is undefined, omit both ports and counter logic entirely; all other behaviour identical.

Verification
REQ-029 Reset then 4 free cycles, ROM = address -> PCF 0 (BOOT), 0, 1, 2; InstrD shows NOP then word 0 then word 1.
REQ-030 PCF = 511, no stall -> next PCF = 0, PCPlus4D = 0 with PCD = 511.
REQ-031 StallF = StallD = 1 for 3 cycles at PCF = 20 -> PCF stays 20, InstrD unchanged; with PCSrcE = 1, PCTargetE = 100 during stall -> PCF = 100 next edge.
REQ-032 PCSrcE = 1 (target 50) and PCReturnSignalE = 1 (PCReturnE = 7) together, FlushD = 1 -> PCF = 7, InstrD = 0.
REQ-033 Halt word at PCF = 9, no redirect -> HaltedF = 1 next edge, PCF stays 9, InstrD = 0 thereafter; same word with PCSrcE = 1 -> no halt; rst pulse in HALT -> PCF = 0, HaltedF = 0.
REQ-034 With FETCH_PERF_COUNT_EN: 10 RUN fetches plus 3 stall cycles -> FetchCountF = 10, StallCountF = 3; preloaded near 16'hFFFF -> saturates.
